// File: rtl/usb_pd_clk_pkg.sv
// Shared definitions for the USB-PD clock/reset generator: FSM encoding,
// default clock rates and the bit-period divider calculation.
package usb_pd_clk_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

  localparam int CLK_HZ_DEF   = 30000000;
  localparam int BIT_RATE_DEF = 300000;

  // Number of clk cycles per BMC unit interval.
  function automatic int calc_div(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/usb_pd_bit_tick.sv
// BMC timing strobe generator. While en is high a counter runs 0..DIV-1;
// half_tick fires twice per UI, bit_tick once per UI. Both strobes are
// registered, so the first bit_tick appears DIV cycles after en rises.
module usb_pd_bit_tick #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic half_tick,
  output logic bit_tick
);

  localparam int TW = $clog2(DIV);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;
  logic          bit_q, bit_d;

  // Counter advance and strobe decode; everything collapses to zero when disabled.
  always_comb begin
    cnt_d  = '0;
    half_d = 1'b0;
    bit_d  = 1'b0;
    if (en) begin
      cnt_d  = (cnt_q == TW'(DIV - 1)) ? '0 : cnt_q + TW'(1);
      half_d = (cnt_q == TW'(DIV / 2 - 1)) || (cnt_q == TW'(DIV - 1));
      bit_d  = (cnt_q == TW'(DIV - 1));
    end
  end

  // Counter and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
      bit_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      bit_q  <= bit_d;
    end
  end

  assign half_tick = half_q;
  assign bit_tick  = bit_q;

endmodule

// File: rtl/usb_pd_clk_rst_gen.sv
// USB-PD clock/reset generator: synchronises PLL lock, filters it for
// stability, holds the PD core in reset for a fixed time after lock is
// qualified, produces BMC strobes while running and counts lock drops.
module usb_pd_clk_rst_gen
  import usb_pd_clk_pkg::*;
#(
  parameter int CLK_HZ          = CLK_HZ_DEF,
  parameter int BIT_RATE        = BIT_RATE_DEF,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int RST_HOLD_CYC    = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int LOSS_CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_lock,
  output logic                  pd_rst,
  output logic                  pd_ready,
  output logic                  bit_tick,
  output logic                  half_tick,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]            state_o
);

  localparam int DIV = calc_div(CLK_HZ, BIT_RATE);
  localparam int CW  = $clog2(LOCK_STABLE_CYC + RST_HOLD_CYC) + 1;

  if ((DIV % 2) != 0 || DIV < 4) begin : g_bad_div
    $fatal(1, "DIV must be even and at least 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "SYNC_STAGES must be at least 2");
  end
  if (LOCK_STABLE_CYC < 1 || RST_HOLD_CYC < 1) begin : g_bad_cyc
    $fatal(1, "LOCK_STABLE_CYC and RST_HOLD_CYC must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pd_rst_q, pd_rst_d;
  logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
  logic                   loss_evt;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock};
  assign lock_s = sync_q[SYNC_STAGES-1];

  // State register plus synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= ST_RST;
      cnt_q    <= '0;
      pd_rst_q <= 1'b1;
      loss_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pd_rst_q <= pd_rst_d;
      loss_q   <= loss_d;
    end
  end

  // Next-state logic: any low on lock_s before RUN restarts qualification.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_evt = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_WAIT;
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (cnt_q == CW'(LOCK_STABLE_CYC - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (cnt_q == CW'(RST_HOLD_CYC - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d  = ST_WAIT;
          loss_evt = 1'b1;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  // Output logic: pd_rst follows the next state so it changes on the RUN entry/exit edge.
  always_comb begin
    pd_rst_d = (state_d != ST_RUN);
    loss_d   = loss_q;
    if (loss_evt && (loss_q != {LOSS_CNT_W{1'b1}})) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  usb_pd_bit_tick #(
    .DIV (DIV)
  ) u_bit_tick (
    .clk       (clk),
    .reset     (reset),
    .en        (state_q == ST_RUN),
    .half_tick (half_tick),
    .bit_tick  (bit_tick)
  );

  assign pd_rst        = pd_rst_q;
  assign pd_ready      = ~pd_rst_q;
  assign lock_loss_cnt = loss_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_usb_pd_clk_rst_gen.sv
// Self-checking bench for usb_pd_clk_rst_gen: directed scenarios with
// hand-computed edge expectations plus randomised lock traffic, all
// compared every cycle against a streak-counting reference model.
module tb_usb_pd_clk_rst_gen;

  localparam int SYNC = 2;
  localparam int LSC  = 8;
  localparam int RHC  = 4;
  localparam int DIV  = 10;
  localparam int HALF = DIV / 2;
  localparam int NQ   = 1 + LSC + RHC; // consecutive lock_s highs needed for RUN

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pd_rst, pd_ready, bit_tick, half_tick;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_o;

  int n_total = 0;
  int n_bad   = 0;

  usb_pd_clk_rst_gen #(
    .CLK_HZ          (3000000),
    .BIT_RATE        (300000),
    .LOCK_STABLE_CYC (LSC),
    .RST_HOLD_CYC    (RHC),
    .SYNC_STAGES     (SYNC),
    .LOSS_CNT_W      (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .pd_rst        (pd_rst),
    .pd_ready      (pd_ready),
    .bit_tick      (bit_tick),
    .half_tick     (half_tick),
    .lock_loss_cnt (lock_loss_cnt),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  // Reference model: lock_s is a delayed copy of pll_lock; the FSM is
  // summarised by how many consecutive high lock_s samples have been seen.
  int  msync [SYNC];
  int  streak, age, mloss, mhalf, mbit, mstate, mrst;
  bit  in_rst, mvalid, ls, was_run;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC; i++) msync[i] = 0;
      in_rst = 1; streak = 0; age = 0; mloss = 0; mhalf = 0; mbit = 0;
      mvalid = 1;
    end else if (mvalid) begin
      ls = (msync[SYNC-1] != 0);
      for (int i = SYNC - 1; i > 0; i--) msync[i] = msync[i-1];
      msync[0] = int'(pll_lock);
      was_run = !in_rst && (streak >= NQ);
      if (was_run) begin
        age++;
        mhalf = (age % HALF == 0) ? 1 : 0;
        mbit  = (age % DIV == 0) ? 1 : 0;
      end else begin
        mhalf = 0;
        mbit  = 0;
      end
      if (in_rst) in_rst = 0;
      else if (ls) begin
        if (streak < NQ) streak++;
      end else begin
        if (was_run && mloss < 255) mloss++;
        streak = 0;
      end
      if (!was_run && streak >= NQ) age = 0;
    end
    mstate = in_rst ? 0 : (streak == 0) ? 1 : (streak <= LSC) ? 2 : (streak < NQ) ? 3 : 4;
    mrst   = (in_rst || streak < NQ) ? 1 : 0;
    #1;
    if (mvalid) begin
      chk("m_state", int'(state_o), mstate);
      chk("m_pd_rst", int'(pd_rst), mrst);
      chk("m_pd_ready", int'(pd_ready), 1 - mrst);
      chk("m_half_tick", int'(half_tick), mhalf);
      chk("m_bit_tick", int'(bit_tick), mbit);
      chk("m_loss_cnt", int'(lock_loss_cnt), mloss);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hi_len, lo_len;
    // Clean lock: lock high before edge 0, then loss in RUN at edge 40.
    reset = 1'b1; pll_lock = 1'b1;
    cyc(3);
    chk("rst_state", int'(state_o), 0);
    chk("rst_pd_rst", int'(pd_rst), 1);
    chk("rst_ticks", int'(half_tick) + int'(bit_tick), 0);
    reset = 1'b0;
    for (int e = 0; e <= 45; e++) begin
      @(negedge clk);
      if (e == 0)  chk("clean_e0_state", int'(state_o), 1);
      if (e == 2)  chk("clean_e2_state", int'(state_o), 2);
      if (e == 10) chk("clean_e10_state", int'(state_o), 3);
      if (e == 13) chk("clean_e13_pd_rst", int'(pd_rst), 1);
      if (e == 14) begin
        chk("clean_e14_pd_rst", int'(pd_rst), 0);
        chk("clean_e14_ready", int'(pd_ready), 1);
        chk("clean_e14_state", int'(state_o), 4);
      end
      if (e == 18) chk("tick_e18_half", int'(half_tick), 0);
      if (e == 19) begin
        chk("tick_e19_half", int'(half_tick), 1);
        chk("tick_e19_bit", int'(bit_tick), 0);
      end
      if (e == 20) chk("tick_e20_half", int'(half_tick), 0);
      if (e == 24) begin
        chk("tick_e24_half", int'(half_tick), 1);
        chk("tick_e24_bit", int'(bit_tick), 1);
      end
      if (e == 25) chk("tick_e25_bit", int'(bit_tick), 0);
      if (e == 34) chk("tick_e34_bit", int'(bit_tick), 1);
      if (e == 39) pll_lock = 1'b0;
      if (e == 41) chk("loss_e41_pd_rst", int'(pd_rst), 0);
      if (e == 42) begin
        chk("loss_e42_pd_rst", int'(pd_rst), 1);
        chk("loss_e42_cnt", int'(lock_loss_cnt), 1);
      end
      if (e == 43) chk("loss_e43_ticks", int'(half_tick) + int'(bit_tick), 0);
    end

    // Reset mid-RUN clears the loss count and restarts qualification.
    pll_lock = 1'b1;
    cyc(20);
    chk("pre_rst_run", int'(state_o), 4);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_pd_rst", int'(pd_rst), 1);
    chk("midrst_loss", int'(lock_loss_cnt), 0);
    chk("midrst_ticks", int'(half_tick) + int'(bit_tick), 0);
    reset = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 14) chk("midrst_k14_pd_rst", int'(pd_rst), 1);
      if (k == 15) chk("midrst_k15_pd_rst", int'(pd_rst), 0);
    end

    // Glitch in STABLE: low sampled at edges 6..8, high again from edge 9.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int e = 0; e <= 25; e++) begin
      @(negedge clk);
      if (e == 5) pll_lock = 1'b0;
      if (e == 8) begin
        pll_lock = 1'b1;
        chk("glitch_e8_state", int'(state_o), 1);
      end
      if (e == 22) chk("glitch_e22_pd_rst", int'(pd_rst), 1);
      if (e == 23) begin
        chk("glitch_e23_pd_rst", int'(pd_rst), 0);
        chk("glitch_e23_loss", int'(lock_loss_cnt), 0);
      end
    end

    // Randomised lock traffic, sub-cycle glitches and occasional resets.
    for (int s = 0; s < 150; s++) begin
      hi_len = $urandom_range(1, 40);
      lo_len = $urandom_range(1, 6);
      pll_lock = 1'b1;
      for (int i = 0; i < hi_len; i++) begin
        @(negedge clk);
        if ($urandom_range(0, 19) == 0) begin
          pll_lock = 1'b0;
          #2 pll_lock = 1'b1;
        end
      end
      pll_lock = 1'b0;
      cyc(lo_len);
      if ($urandom_range(0, 14) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
    end

    // Saturation: 300 RUN entries each followed by a lock drop.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int r = 0; r < 300; r++) begin
      pll_lock = 1'b1;
      cyc(18);
      pll_lock = 1'b0;
      cyc(3);
      if (r == 9) chk("sat_r10_cnt", int'(lock_loss_cnt), 10);
    end
    chk("sat_cnt", int'(lock_loss_cnt), 255);
    cyc(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
